// File: rtl/div_reconstructor_seq_if.sv
// div_reconstructor_seq_if: operand/result handshake bundle for the dividend reconstructor
interface div_reconstructor_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  d;
  logic [7:0]  r;
  logic [15:0] n_ref;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_rec;
  logic [15:0] err;
  logic        mismatch;
  modport master (
    output in_valid, q, d, r, n_ref, out_ready,
    input  in_ready, out_valid, n_rec, err, mismatch
  );
  modport slave (
    input  in_valid, q, d, r, n_ref, out_ready,
    output in_ready, out_valid, n_rec, err, mismatch
  );
endinterface

// File: rtl/div_reconstructor_seq.sv
// div_reconstructor_seq: rebuilds q*d+r by 8-step shift-add; DIV_RECON_ERROR_METRIC_EN adds |n_ref-n_rec| check
module div_reconstructor_seq (
  input logic clk,
  input logic rst,
  div_reconstructor_seq_if.slave b
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  qs_q, qs_d;
`ifdef DIV_RECON_ERROR_METRIC_EN
  logic [15:0] nref_q, nref_d;
  logic [15:0] err_q, err_d;
  logic        mis_q, mis_d;
`endif
  // next state: accept in IDLE, one shift-add per MUL cycle, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    qs_d    = qs_q;
`ifdef DIV_RECON_ERROR_METRIC_EN
    nref_d  = nref_q;
    err_d   = err_q;
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: if (b.in_valid) begin
        state_d = MUL;
        qs_d    = b.q;
        mcand_d = {8'h00, b.d};
        acc_d   = {8'h00, b.r};
        count_d = 4'd0;
`ifdef DIV_RECON_ERROR_METRIC_EN
        nref_d  = b.n_ref;
`endif
      end
      MUL: begin
        acc_d   = acc_q + (qs_q[0] ? mcand_q << count_q : 16'h0000);
        qs_d    = qs_q >> 1;
        count_d = count_q + 4'd1;
        if (count_q == 4'd7) begin
          state_d = DONE;
`ifdef DIV_RECON_ERROR_METRIC_EN
          err_d   = nref_q > acc_d ? nref_q - acc_d : acc_d - nref_q;
          mis_d   = err_d != 16'h0000;
`endif
        end
      end
      DONE: if (b.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      acc_q   <= 16'h0000;
      mcand_q <= 16'h0000;
      qs_q    <= 8'h00;
`ifdef DIV_RECON_ERROR_METRIC_EN
      nref_q  <= 16'h0000;
      err_q   <= 16'h0000;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      qs_q    <= qs_d;
`ifdef DIV_RECON_ERROR_METRIC_EN
      nref_q  <= nref_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
`endif
    end
  end
  assign b.in_ready  = state_q == IDLE;
  assign b.out_valid = state_q == DONE;
  assign b.n_rec     = acc_q;
`ifdef DIV_RECON_ERROR_METRIC_EN
  assign b.err       = err_q;
  assign b.mismatch  = mis_q;
`else
  logic unused_nref;
  assign unused_nref = ^b.n_ref;
  assign b.err       = 16'h0000;
  assign b.mismatch  = 1'b0;
`endif
endmodule

// File: tb/tb_div_reconstructor_seq.sv
// tb_div_reconstructor_seq: directed checks of latency, handshake, reset abort and error metric
module tb_div_reconstructor_seq;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  div_reconstructor_seq_if bus();
  div_reconstructor_seq dut (.clk(clk), .rst(rst), .b(bus.slave));
  always #5 clk = ~clk;
`ifdef DIV_RECON_ERROR_METRIC_EN
  localparam bit METRIC = 1'b1;
`else
  localparam bit METRIC = 1'b0;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                     input logic [15:0] nref, input logic [15:0] exp_rec, input logic [15:0] exp_err);
    bus.in_valid = 1'b1;
    bus.q = q;
    bus.d = d;
    bus.r = r;
    bus.n_ref = nref;
    tick();
    bus.in_valid = 1'b0;
    chk("in_ready_busy", {15'd0, bus.in_ready}, 16'd0);
    repeat (7) tick();
    chk("out_valid_early", {15'd0, bus.out_valid}, 16'd0);
    tick();
    chk("out_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("n_rec", bus.n_rec, exp_rec);
    chk("err", bus.err, METRIC ? exp_err : 16'h0000);
    chk("mismatch", {15'd0, bus.mismatch}, {15'd0, METRIC && exp_err != 16'h0000});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("in_ready_back", {15'd0, bus.in_ready}, 16'd1);
    chk("out_valid_drop", {15'd0, bus.out_valid}, 16'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.q = 8'h00;
    bus.d = 8'h00;
    bus.r = 8'h00;
    bus.n_ref = 16'h0000;
    tick();
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_n_rec", bus.n_rec, 16'h0000);
    chk("rst_err", bus.err, 16'h0000);
    chk("rst_mismatch", {15'd0, bus.mismatch}, 16'd0);
    rst = 1'b0;
    run(8'h12, 8'h0D, 8'h05, 16'h1000, 16'h00EF, 16'h0F11);
    run(8'h12, 8'h0D, 8'h05, 16'h00EF, 16'h00EF, 16'h0000);
    run(8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 16'hFEFF, 16'h0000);
    run(8'h00, 8'h00, 8'h00, 16'h0005, 16'h0000, 16'h0005);
    run(8'hFF, 8'hFF, 8'hFF, 16'h0000, 16'hFF00, 16'hFF00);
    run(8'h80, 8'h01, 8'h00, 16'h0080, 16'h0080, 16'h0000);
    bus.in_valid = 1'b1;
    bus.q = 8'h34;
    bus.d = 8'h05;
    bus.r = 8'h07;
    bus.n_ref = 16'h010B;
    tick();
    bus.q = 8'hAA;
    bus.d = 8'h55;
    bus.r = 8'h33;
    bus.n_ref = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    chk("hold_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("hold_n_rec", bus.n_rec, 16'h010B);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      tick();
      chk("hold_stable", bus.n_rec, 16'h010B);
      chk("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
    end
    chk("hold_err", bus.err, 16'h0000);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("handshake_idle", {15'd0, bus.in_ready}, 16'd1);
    bus.in_valid = 1'b1;
    bus.q = 8'hAB;
    bus.d = 8'hCD;
    bus.r = 8'h11;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("abort_n_rec", bus.n_rec, 16'h0000);
    chk("abort_in_ready", {15'd0, bus.in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    run(8'h12, 8'h0D, 8'h05, 16'h1000, 16'h00EF, 16'h0F11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
